// File: rtl/if_hart_fetch.sv
// Multi-hart instruction fetch stage: per-hart PC/active table, round-robin
// hart select, I-mem request/ready handshake and the IF/ID pipeline register.

// One PC table entry: PC register plus active bit for a single hart.
module if_hart_pc_entry #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter bit          RESET_ACT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_en,    // EX redirect targets this hart
    input  logic [31:0] br_addr,
    input  logic        st_en,    // start command targets this hart
    input  logic [31:0] st_pc,
    input  logic        kill_en,  // kill command targets this hart
    input  logic        inc_en,   // this hart's fetch was accepted
    output logic [31:0] pc,
    output logic        active
);
    // A start is honoured only for an idle hart that is not being killed in the same cycle.
    logic st_ok;
    assign st_ok = st_en & ~active & ~kill_en;

    // Active bit: kill beats start. PC: redirect > start > sequential +4.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            active <= RESET_ACT;
        end else begin
            if (kill_en)    active <= 1'b0;
            else if (st_ok) active <= 1'b1;
            if (br_en)       pc <= br_addr;
            else if (st_ok)  pc <= st_pc;
            else if (inc_en) pc <= pc + 32'd4;
        end
    end
endmodule

module if_hart_fetch #(
    parameter int          HART_NUM     = 4,
    parameter int          HART_ID_W    = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 br_taken,
    input  logic [HART_ID_W-1:0] br_hart_id,
    input  logic [31:0]          br_addr,
    input  logic                 id_hstart,
    input  logic [HART_ID_W-1:0] id_hs_id,
    input  logic [31:0]          id_hs_pc,
    input  logic                 id_hkill,
    input  logic [HART_ID_W-1:0] id_set_hid,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_rdy,
    input  logic [31:0]          imem_rd_data,
    output logic [HART_NUM-1:0]  hart_active,
    output logic [31:0]          if_cur_pc,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_insn,
    output logic                 if_en,
    output logic [HART_ID_W-1:0] if_hart_id
);
    typedef struct packed {
        logic                 en;
        logic [HART_ID_W-1:0] hid;
        logic [31:0]          cur_pc;
        logic [31:0]          nxt_pc;
        logic [31:0]          insn;
    } ifid_t;

    logic [HART_NUM-1:0][31:0] pc_tab;
    logic [HART_ID_W-1:0]      rr_ptr;
    logic [HART_ID_W-1:0]      sel;
    logic [HART_ID_W-1:0]      idx;
    logic                      found;
    logic                      any_act;
    logic                      kill_sel;
    logic                      accept;
    logic [31:0]               sel_pc;
    ifid_t                     ifid;

    genvar h;
    generate
        for (h = 0; h < HART_NUM; h++) begin : g_hart
            if_hart_pc_entry #(
                .RESET_PC  ((h == 0) ? RESET_VECTOR : 32'h0),
                .RESET_ACT (h == 0)
            ) u_entry (
                .clk     (clk),
                .reset   (reset),
                .br_en   (br_taken  && (br_hart_id == HART_ID_W'(h))),
                .br_addr (br_addr),
                .st_en   (id_hstart && (id_hs_id   == HART_ID_W'(h))),
                .st_pc   (id_hs_pc),
                .kill_en (id_hkill  && (id_set_hid == HART_ID_W'(h))),
                .inc_en  (accept    && (sel        == HART_ID_W'(h))),
                .pc      (pc_tab[h]),
                .active  (hart_active[h])
            );
        end
    endgenerate

    // Round-robin pick: first active hart at or after rr_ptr, wrapping mod HART_NUM.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < HART_NUM; k++) begin
            idx = rr_ptr + HART_ID_W'(k);
            if (!found && hart_active[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign any_act   = |hart_active;
    assign sel_pc    = pc_tab[sel];
    assign imem_req  = any_act & ~stall;
    assign imem_addr = any_act ? sel_pc : 32'h0;
    assign kill_sel  = id_hkill & (id_set_hid == sel);
    assign accept    = imem_req & imem_rdy & ~flush & ~kill_sel;

    // Pointer moves past the served hart only when its fetch is taken.
    always_ff @(posedge clk) begin
        if (reset)       rr_ptr <= '0;
        else if (accept) rr_ptr <= sel + HART_ID_W'(1);
    end

    // IF/ID register: load on accept, bubble otherwise (PC fields kept), hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid <= '{en: 1'b0, hid: '0, cur_pc: 32'h0, nxt_pc: 32'h0, insn: NOP_INSN};
        end else if (!stall) begin
            if (accept) begin
                ifid <= '{en: 1'b1, hid: sel, cur_pc: sel_pc, nxt_pc: sel_pc + 32'd4,
                          insn: imem_rd_data};
            end else begin
                ifid.en   <= 1'b0;
                ifid.insn <= NOP_INSN;
            end
        end
    end

    assign if_en      = ifid.en;
    assign if_hart_id = ifid.hid;
    assign if_cur_pc  = ifid.cur_pc;
    assign if_pc      = ifid.nxt_pc;
    assign if_insn    = ifid.insn;
endmodule

// File: tb/tb_if_hart_fetch.sv
// Directed bench for if_hart_fetch: reset, round-robin, redirect, stall,
// bubbles/flush, kill/start and PC wrap, reset during fetch.
module tb_if_hart_fetch;
    localparam logic [31:0] K   = 32'h5A5A_0000;  // instruction = address ^ K
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken, id_hstart, id_hkill, imem_rdy;
    logic [1:0]  br_hart_id, id_hs_id, id_set_hid, if_hart_id;
    logic [31:0] br_addr, id_hs_pc, imem_addr, imem_rd_data, if_cur_pc, if_pc, if_insn;
    logic        imem_req, if_en;
    logic [3:0]  hart_active;

    int vecs = 0;
    int errs = 0;

    if_hart_fetch dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .br_taken(br_taken), .br_hart_id(br_hart_id), .br_addr(br_addr),
        .id_hstart(id_hstart), .id_hs_id(id_hs_id), .id_hs_pc(id_hs_pc),
        .id_hkill(id_hkill), .id_set_hid(id_set_hid),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
        .imem_rd_data(imem_rd_data), .hart_active(hart_active),
        .if_cur_pc(if_cur_pc), .if_pc(if_pc), .if_insn(if_insn),
        .if_en(if_en), .if_hart_id(if_hart_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 0; flush = 0; br_taken = 0; br_hart_id = 0; br_addr = 0;
        id_hstart = 0; id_hs_id = 0; id_hs_pc = 0; id_hkill = 0; id_set_hid = 0;
    endtask

    task automatic test_reset();
        reset = 1; imem_rdy = 1; imem_rd_data = 32'hFFFF_FFFF; clr();
        tick(); tick();
        reset = 0; #1;
        vecs++;
        if ({if_en, if_insn, if_cur_pc, if_pc, if_hart_id} !== {1'b0, NOP, 32'h0, 32'h0, 2'd0}) begin
            errs++; $display("FAIL reset_ifid: got en=%b insn=%h cur=%h pc=%h hid=%0d", if_en, if_insn, if_cur_pc, if_pc, if_hart_id);
        end
        vecs++;
        if ({hart_active, imem_req, imem_addr} !== {4'b0001, 1'b1, 32'h0}) begin
            errs++; $display("FAIL reset_sel: got act=%b req=%b addr=%h, want 0001 1 0", hart_active, imem_req, imem_addr);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ea;
            ea = 32'(i * 4);
            vecs++;
            if (imem_addr !== ea) begin errs++; $display("FAIL basic_addr%0d: got %h want %h", i, imem_addr, ea); end
            imem_rd_data = ea ^ K;
            tick();
            vecs++;
            if ({if_en, if_hart_id, if_cur_pc, if_pc, if_insn} !== {1'b1, 2'd0, ea, ea + 32'd4, ea ^ K}) begin
                errs++; $display("FAIL basic_ifid%0d: got en=%b hid=%0d cur=%h pc=%h insn=%h want cur=%h", i, if_en, if_hart_id, if_cur_pc, if_pc, if_insn, ea);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] ea_t [0:2] = '{32'h0C, 32'h200, 32'h100};
        logic [1:0]  eh_t [0:2] = '{2'd0, 2'd1, 2'd2};
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin id_hstart = 1; id_hs_id = 2; id_hs_pc = 32'h100; end
            #1;
            vecs++;
            if (imem_addr !== ea_t[i]) begin errs++; $display("FAIL rr_addr%0d: got %h want %h", i, imem_addr, ea_t[i]); end
            imem_rd_data = ea_t[i] ^ K;
            tick();
            clr();
            vecs++;
            if ({if_en, if_hart_id, if_cur_pc, if_insn} !== {1'b1, eh_t[i], ea_t[i], ea_t[i] ^ K}) begin
                errs++; $display("FAIL rr_ifid%0d: got en=%b hid=%0d cur=%h want hid=%0d cur=%h", i, if_en, if_hart_id, if_cur_pc, eh_t[i], ea_t[i]);
            end
            if (i == 0) begin
                // hold off fetch for a cycle while hart1 is started
                imem_rdy = 0; id_hstart = 1; id_hs_id = 1; id_hs_pc = 32'h200;
                tick();
                clr(); imem_rdy = 1;
                vecs++;
                if ({if_en, hart_active} !== {1'b0, 4'b0111}) begin
                    errs++; $display("FAIL rr_start: got en=%b act=%b want 0 0111", if_en, hart_active);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ea_t [0:3] = '{32'h10, 32'h204, 32'h104, 32'h80};
        logic [1:0]  eh_t [0:3] = '{2'd0, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin br_taken = 1; br_hart_id = 0; br_addr = 32'h80; end
            #1;
            vecs++;
            if (imem_addr !== ea_t[i]) begin errs++; $display("FAIL br_addr%0d: got %h want %h", i, imem_addr, ea_t[i]); end
            imem_rd_data = ea_t[i] ^ K;
            tick();
            clr();
            vecs++;
            if ({if_en, if_hart_id, if_cur_pc, if_pc} !== {1'b1, eh_t[i], ea_t[i], ea_t[i] + 32'd4}) begin
                errs++; $display("FAIL br_ifid%0d: got en=%b hid=%0d cur=%h pc=%h want cur=%h", i, if_en, if_hart_id, if_cur_pc, if_pc, ea_t[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ea_t [0:2] = '{32'h208, 32'h108, 32'h84};
        logic [1:0]  eh_t [0:2] = '{2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            stall = 1; imem_rd_data = 32'hBAD0_0000; #1;
            vecs++;
            if ({imem_req, imem_addr} !== {1'b0, 32'h208}) begin
                errs++; $display("FAIL stall_sel%0d: got req=%b addr=%h want 0 208", i, imem_req, imem_addr);
            end
            tick();
            vecs++;
            if ({if_en, if_hart_id, if_cur_pc, if_insn} !== {1'b1, 2'd0, 32'h80, 32'h80 ^ K}) begin
                errs++; $display("FAIL stall_hold%0d: got en=%b hid=%0d cur=%h insn=%h want cur=80", i, if_en, if_hart_id, if_cur_pc, if_insn);
            end
        end
        stall = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if (imem_addr !== ea_t[i]) begin errs++; $display("FAIL stall_resume_addr%0d: got %h want %h", i, imem_addr, ea_t[i]); end
            imem_rd_data = ea_t[i] ^ K;
            tick();
            vecs++;
            if ({if_en, if_hart_id, if_cur_pc} !== {1'b1, eh_t[i], ea_t[i]}) begin
                errs++; $display("FAIL stall_resume%0d: got en=%b hid=%0d cur=%h want %h", i, if_en, if_hart_id, if_cur_pc, ea_t[i]);
            end
        end
    endtask

    task automatic test_bubble_flush();
        for (int i = 0; i < 3; i++) begin
            imem_rdy = (i == 2); flush = (i == 2); imem_rd_data = 32'hBAD0_0001; #1;
            vecs++;
            if (imem_addr !== 32'h20C) begin errs++; $display("FAIL bubble_addr%0d: got %h want 20c", i, imem_addr); end
            tick();
            vecs++;
            if ({if_en, if_insn, if_cur_pc, if_pc} !== {1'b0, NOP, 32'h84, 32'h88}) begin
                errs++; $display("FAIL bubble_ifid%0d: got en=%b insn=%h cur=%h pc=%h want 0 13 84 88", i, if_en, if_insn, if_cur_pc, if_pc);
            end
        end
        imem_rdy = 1; flush = 0; #1;
        vecs++;
        if (imem_addr !== 32'h20C) begin errs++; $display("FAIL bubble_retry_addr: got %h want 20c", imem_addr); end
        imem_rd_data = 32'h20C ^ K;
        tick();
        vecs++;
        if ({if_en, if_hart_id, if_cur_pc} !== {1'b1, 2'd1, 32'h20C}) begin
            errs++; $display("FAIL bubble_retry: got en=%b hid=%0d cur=%h want 1 1 20c", if_en, if_hart_id, if_cur_pc);
        end
        stall = 1; flush = 1;
        tick();
        vecs++;
        if ({if_en, if_cur_pc, if_insn} !== {1'b1, 32'h20C, 32'h20C ^ K}) begin
            errs++; $display("FAIL stall_over_flush: got en=%b cur=%h insn=%h want 1 20c", if_en, if_cur_pc, if_insn);
        end
        clr();
    endtask

    task automatic test_kill_wrap();
        logic [31:0] ea_t [0:2] = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        stall = 1; id_hkill = 1; id_set_hid = 1; tick();
        id_set_hid = 2; tick();
        vecs++;
        if (hart_active !== 4'b0001) begin errs++; $display("FAIL kill_others: got act=%b want 0001", hart_active); end
        stall = 0; id_set_hid = 0; #1;
        vecs++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h88}) begin
            errs++; $display("FAIL kill_sel_addr: got req=%b addr=%h want 1 88", imem_req, imem_addr);
        end
        tick();
        vecs++;
        if ({if_en, hart_active} !== {1'b0, 4'b0000}) begin
            errs++; $display("FAIL kill_last: got en=%b act=%b want 0 0000", if_en, hart_active);
        end
        clr();
        id_hstart = 1; id_hs_id = 0; id_hs_pc = 32'h500; id_hkill = 1; id_set_hid = 0; #1;
        vecs++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
            errs++; $display("FAIL none_active: got req=%b addr=%h want 0 0", imem_req, imem_addr);
        end
        tick();
        vecs++;
        if ({if_en, hart_active} !== {1'b0, 4'b0000}) begin
            errs++; $display("FAIL kill_beats_start: got en=%b act=%b want 0 0000", if_en, hart_active);
        end
        clr();
        id_hstart = 1; id_hs_id = 3; id_hs_pc = 32'hFFFF_FFFC; tick();
        clr();
        vecs++;
        if (hart_active !== 4'b1000) begin errs++; $display("FAIL start_h3: got act=%b want 1000", hart_active); end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                // start of an already-active hart is ignored; redirect of an idle hart keeps it idle
                id_hstart = 1; id_hs_id = 3; id_hs_pc = 32'h700;
                br_taken = 1; br_hart_id = 1; br_addr = 32'h900;
            end
            #1;
            vecs++;
            if (imem_addr !== ea_t[i]) begin errs++; $display("FAIL wrap_addr%0d: got %h want %h", i, imem_addr, ea_t[i]); end
            imem_rd_data = ea_t[i] ^ K;
            tick();
            clr();
            vecs++;
            if ({if_en, if_hart_id, if_cur_pc, if_pc, hart_active} !== {1'b1, 2'd3, ea_t[i], ea_t[i] + 32'd4, 4'b1000}) begin
                errs++; $display("FAIL wrap_ifid%0d: got en=%b hid=%0d cur=%h pc=%h act=%b want cur=%h", i, if_en, if_hart_id, if_cur_pc, if_pc, hart_active, ea_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1; imem_rdy = 1; imem_rd_data = 32'hBAD0_0002;
        tick();
        reset = 0; #1;
        vecs++;
        if ({if_en, if_insn, if_hart_id, hart_active, imem_addr} !== {1'b0, NOP, 2'd0, 4'b0001, 32'h0}) begin
            errs++; $display("FAIL reset_mid: got en=%b insn=%h hid=%0d act=%b addr=%h", if_en, if_insn, if_hart_id, hart_active, imem_addr);
        end
        imem_rd_data = 32'h0 ^ K;
        tick();
        vecs++;
        if ({if_en, if_cur_pc, if_insn} !== {1'b1, 32'h0, K}) begin
            errs++; $display("FAIL reset_mid_fetch: got en=%b cur=%h insn=%h want 1 0 %h", if_en, if_cur_pc, if_insn, K);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_branch();
        test_stall();
        test_bubble_flush();
        test_kill_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
